// File: rtl/rotate_nbit_seq.sv
// Sequenced N-bit rotate register: parallel load plus a rotate of `amount` positions in either direction.
// Optional macro ROTATE_BARREL_EN replaces the serial one-bit-per-edge rotate with a single-edge barrel rotate.
module rotate_nbit_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | accepting load/start; data_out held otherwise
  // ROT   | rotation in progress; all request inputs ignored

  typedef enum logic {IDLE, ROT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             done_nxt;

`ifdef ROTATE_BARREL_EN
  // dir: 1 = left, 0 = right; s must already be reduced below WIDTH
  function automatic logic [WIDTH-1:0] rot_n(input logic [WIDTH-1:0] d, input logic left,
                                             input int unsigned s);
    logic [2*WIDTH-1:0] tmp;
    tmp = {d, d};
    if (left) begin
      tmp = tmp << s;
      return tmp[2*WIDTH-1:WIDTH];
    end
    tmp = tmp >> s;
    return tmp[WIDTH-1:0];
  endfunction
`else
  function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] d, input logic left);
    return left ? {d[WIDTH-2:0], d[WIDTH-1]} : {d[0], d[WIDTH-1:1]};
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      dir_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= data_nxt;
      cnt      <= cnt_nxt;
      dir_q    <= dir_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          data_nxt = data_in;
        end else if (start) begin
          if (amount == '0) begin
            done_nxt = 1'b1;
          end else begin
            cnt_nxt   = amount;
            dir_nxt   = dir;
            state_nxt = ROT;
          end
        end
      end
      ROT: begin
`ifdef ROTATE_BARREL_EN
        data_nxt  = rot_n(data_out, dir_q, int'(cnt) % WIDTH);
        cnt_nxt   = '0;
        state_nxt = IDLE;
        done_nxt  = 1'b1;
`else
        data_nxt = rot1(data_out, dir_q);
        cnt_nxt  = cnt - AMT_W'(1);
        // terminal count: this edge performs the last rotate
        if (cnt == AMT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ROT);

endmodule

// File: tb/tb_rotate_nbit_seq.sv
// Directed self-checking bench for rotate_nbit_seq (WIDTH=8, AMT_W=3); adapts expected latency to ROTATE_BARREL_EN.
module tb_rotate_nbit_seq;
  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  rotate_nbit_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in), .start(start),
    .dir(dir), .amount(amount), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] load_val;
    logic       dir;
    logic [2:0] amt;
    logic [7:0] exp_data;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_busy(input int k);
`ifdef ROTATE_BARREL_EN
    return (k > 0) ? 1 : 0;
`else
    return k;
`endif
  endfunction

  // counts busy cycles from the current negedge until done is seen
  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input vec_t v);
    int bc;
    bit seen;
    load = 1'b1;
    data_in = v.load_val;
    @(negedge clk);
    check($sformatf("%s_load", v.name), 32'(data_out), 32'(v.load_val));
    load = 1'b0;
    start = 1'b1;
    dir = v.dir;
    amount = v.amt;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, seen);
    check($sformatf("%s_done_seen", v.name), 32'(seen), 32'd1);
    check($sformatf("%s_busy_cycles", v.name), 32'(bc), 32'(exp_busy(int'(v.amt))));
    check($sformatf("%s_data", v.name), 32'(data_out), 32'(v.exp_data));
    check($sformatf("%s_busy_at_done", v.name), 32'(busy), 32'd0);
    @(negedge clk);
    check($sformatf("%s_done_pulse", v.name), 32'(done), 32'd0);
    check($sformatf("%s_hold", v.name), 32'(data_out), 32'(v.exp_data));
  endtask

  initial begin
    int bc;
    bit seen;

    vecs[0] = '{8'hB4, 1'b1, 3'd3, 8'hA5, "rl3_b4"};
    vecs[1] = '{8'h81, 1'b0, 3'd1, 8'hC0, "rr1_81"};
    vecs[2] = '{8'h5A, 1'b1, 3'd0, 8'h5A, "zero_5a"};
    vecs[3] = '{8'h01, 1'b1, 3'd7, 8'h80, "rl7_01"};
    vecs[4] = '{8'h01, 1'b0, 3'd1, 8'h80, "rr1_01"};
    vecs[5] = '{8'h96, 1'b0, 3'd4, 8'h69, "rr4_96"};
    vecs[6] = '{8'hC3, 1'b1, 3'd5, 8'h78, "rl5_c3"};
    vecs[7] = '{8'h3C, 1'b1, 3'd2, 8'hF0, "rl2_3c"};

    #1 reset_n = 1'b0;
    #1;
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(data_out), 32'h00);

    foreach (vecs[i]) run_op(vecs[i]);

    // back-to-back: new start issued in the done cycle
    load = 1'b1;
    data_in = 8'h01;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    dir = 1'b1;
    amount = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, seen);
    check("b2b_first_done", 32'(seen), 32'd1);
    check("b2b_first_data", 32'(data_out), 32'h02);
    start = 1'b1;
    dir = 1'b1;
    amount = 3'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    wait_done(bc, seen);
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_second_busy_cycles", 32'(bc), 32'(exp_busy(2)));
    check("b2b_second_data", 32'(data_out), 32'h08);
    @(negedge clk);

    // requests during ROT ignored, then reset mid-rotation
    load = 1'b1;
    data_in = 8'h01;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1;
    dir = 1'b1;
    amount = 3'd7;
    @(negedge clk);
    load = 1'b1;
    data_in = 8'hFF;
    start = 1'b1;
    dir = 1'b0;
    amount = 3'd1;
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    amount = 3'd0;
`ifdef ROTATE_BARREL_EN
    check("ign_data", 32'(data_out), 32'h80);
    check("ign_done", 32'(done), 32'd1);
`else
    check("ign_data", 32'(data_out), 32'h02);
    check("ign_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("two_rot_data", 32'(data_out), 32'h04);
    check("two_rot_busy", 32'(busy), 32'd1);
`endif
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrot_rst_data", 32'(data_out), 32'h00);
    check("midrot_rst_busy", 32'(busy), 32'd0);
    check("midrot_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    dir = 1'b1;
    amount = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("rel_start_busy", 32'(busy), 32'd1);
    wait_done(bc, seen);
    check("rel_done", 32'(seen), 32'd1);
    check("rel_busy_cycles", 32'(bc), 32'(exp_busy(3)));
    check("rel_data", 32'(data_out), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
